// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the memory read/write port
// Optional feature: ARB_ROUND_ROBIN_EN selects alternating grants instead of data-first priority.
module mem_port_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic [WORD_SIZE-1:0] i_rdata,
   output logic                 i_ready,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_ready,
   output logic                 readM2,
   output logic                 writeM2,
   output logic [WORD_SIZE-1:0] address2,
   inout  wire  [WORD_SIZE-1:0] data2
);

   typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 wr_q, wr_d;
   logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
   logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
   logic                 i_ready_q, i_ready_d;
   logic                 d_ready_q, d_ready_d;
   logic                 d_pend;
   logic                 take_d;

   assign d_pend = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   // last_grant_q: 0 = instruction, 1 = data
   logic last_grant_q, last_grant_d;

   always_comb begin
      if (d_pend && i_req) begin
         take_d = ~last_grant_q;
      end else begin
         take_d = d_pend;
      end
   end
`else
   assign take_d = d_pend;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (take_d) begin
               state_d = D_ACC;
               cnt_d   = 4'd0;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               wr_d    = d_write;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = 1'b1;
`endif
            end else if (i_req) begin
               state_d = I_ACC;
               cnt_d   = 4'd0;
               addr_d  = i_addr;
               wr_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = 1'b0;
`endif
            end
         end
         I_ACC, D_ACC: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               // Memory data has been stable since the first strobed edge; sample it on the last one.
               if (state_q == I_ACC) begin
                  i_rdata_d = data2;
                  i_ready_d = 1'b1;
               end else begin
                  if (!wr_q) d_rdata_d = data2;
                  d_ready_d = 1'b1;
               end
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_q      <= wr_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign readM2   = ((state_q == I_ACC) || (state_q == D_ACC)) && !wr_q;
   assign writeM2  = (state_q == D_ACC) && wr_q;
   assign address2 = addr_q;
   assign data2    = writeM2 ? wdata_q : {WORD_SIZE{1'bz}};
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign i_ready  = i_ready_q;
   assign d_ready  = d_ready_q;

endmodule
